// File: rtl/debounce_pkg.sv
// Shared types for the debounce filter: FSM state encoding and counter sizing.
// Imported by debounce_filter.
package debounce_pkg;

    typedef enum logic [1:0] {S_LO, S_LO2HI, S_HI, S_HI2LO} deb_state_e;

    function automatic int cnt_w(input int stable_cyc);
        return $clog2(stable_cyc + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input, async-reset to RST_VAL.
// Shared with the edge-to-enable stages.
module sync_chain #(
    parameter int   STG     = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STG-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {STG{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STG; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STG-1];

endmodule

// File: rtl/debounce_filter.sv
// Synchronise a bouncy async input and accept level changes only after STABLE_CYC stable clocks.
// Optional rejected-transition counter enabled by DEBOUNCE_GLITCH_CNT_EN.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int   SYNC_STG   = 2,
    parameter int   STABLE_CYC = 16,
    parameter logic RST_VAL    = 1'b0,
    parameter int   GLITCH_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_raw,
    output logic                out,
    output logic                rise,
    output logic                fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int             CW       = cnt_w(STABLE_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYC - 1);
    localparam deb_state_e     ST_RST   = RST_VAL ? S_HI : S_LO;

    if (SYNC_STG < 1 || STABLE_CYC < 1 || GLITCH_W < 1) begin : g_param_chk
        $error("debounce_filter: SYNC_STG, STABLE_CYC and GLITCH_W must all be >= 1");
    end

    logic          s;
    deb_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          out_nxt, rise_nxt, fall_nxt;

    sync_chain #(.STG(SYNC_STG), .RST_VAL(RST_VAL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in_raw),
        .q   (s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RST;
            cnt   <= '0;
            out   <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // cnt holds how many consecutive cycles s has disagreed with the committed level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LO: begin
                if (s) begin
                    if (STABLE_CYC == 1) begin
                        state_nxt = S_HI;
                        out_nxt   = 1'b1;
                        rise_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_LO2HI;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            S_LO2HI: begin
                if (!s) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HI;
                    out_nxt   = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_HI: begin
                if (!s) begin
                    if (STABLE_CYC == 1) begin
                        state_nxt = S_LO;
                        out_nxt   = 1'b0;
                        fall_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_HI2LO;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            S_HI2LO: begin
                if (s) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LO;
                    out_nxt   = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic abort;

    assign abort = (state == S_LO2HI && !s) || (state == S_HI2LO && s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (abort && glitch_cnt != '1) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end
`endif

endmodule
